// File: rtl/qpsk_rx_deframer.sv
// QPSK receive deframer: collects a block of 2-bit symbols, Hamming(7,4)-decodes each codeword
// and presents the data on a valid/ready port. Define QPSK_RX_ERRCNT_EN to add the err_cnt counter.
module qpsk_rx_deframer #(
  parameter int N_CW      = 4,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sym_valid,
  input  logic                 sym_sof,
  input  logic [1:0]           sym_data,
  output logic                 sym_ready,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [4*N_CW-1:0]    dec_data,
  output logic [N_CW-1:0]      dec_err,
  output logic                 frm_err
`ifdef QPSK_RX_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int BLK_W = 7 * N_CW;
  localparam int SYMS  = BLK_W / 2;
  localparam int CNT_W = $clog2(SYMS);

  if ((N_CW % 2) != 0 || N_CW < 2 || ERR_CNT_W < 1) begin : g_bad_param
    $error("qpsk_rx_deframer: N_CW must be even and >= 2, ERR_CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECODE  = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [CNT_W-1:0]   wr_idx;
  logic               wr_en;
  logic               frm_err_nxt;
  logic               load_dec;
  logic [BLK_W-1:0]   block;
  logic [4*N_CW-1:0]  dec_data_nxt;
  logic [N_CW-1:0]    dec_err_nxt;
  logic [6:0]         cw;
  logic [2:0]         syn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      frm_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state   <= state_nxt;
      count   <= count_nxt;
      frm_err <= frm_err_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt   = state;
    count_nxt   = count;
    frm_err_nxt = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = count;
    load_dec    = 1'b0;
    sym_ready   = 1'b0;
    dec_valid   = 1'b0;

    unique case (state)
      IDLE: begin
        sym_ready = 1'b1;
        if (sym_valid && sym_sof) begin
          wr_en     = 1'b1;
          wr_idx    = '0;
          count_nxt = CNT_W'(1);
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        sym_ready = 1'b1;
        if (sym_valid) begin
          wr_en = 1'b1;
          if (sym_sof) begin
            // A new frame start mid-block abandons the partial block and restarts at k=0.
            wr_idx      = '0;
            count_nxt   = CNT_W'(1);
            frm_err_nxt = 1'b1;
          end else if (count == CNT_W'(SYMS - 1)) begin
            count_nxt = '0;
            state_nxt = DECODE;
          end else begin
            count_nxt = count + CNT_W'(1);
          end
        end
      end
      DECODE: begin
        load_dec  = 1'b1;
        state_nxt = OUTPUT;
      end
      OUTPUT: begin
        dec_valid = 1'b1;
        if (dec_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the block buffer is pure data that is fully rewritten before each decode, so it has no reset.
  always_ff @(posedge clk) begin
    if (wr_en) block[{wr_idx, 1'b0} +: 2] <= sym_data;
  end

  // Codeword bit j is Hamming position j+1; the syndrome names the flipped position directly.
  always_comb begin
    dec_data_nxt = '0;
    dec_err_nxt  = '0;
    cw           = '0;
    syn          = '0;
    for (int i = 0; i < N_CW; i++) begin
      cw     = block[7*i +: 7];
      syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
      syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
      syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
      if (syn != 3'd0) cw[syn - 3'd1] = ~cw[syn - 3'd1];
      dec_data_nxt[4*i +: 4] = {cw[6], cw[5], cw[4], cw[2]};
      dec_err_nxt[i]         = |syn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_data <= '0;
      dec_err  <= '0;
    end else if (load_dec) begin
      dec_data <= dec_data_nxt;
      dec_err  <= dec_err_nxt;
    end
  end

`ifdef QPSK_RX_ERRCNT_EN
  localparam int POP_W = $clog2(N_CW + 1);
  localparam int SUM_W = ERR_CNT_W + 1;

  logic [POP_W-1:0] err_pop;
  logic [SUM_W-1:0] err_sum;

  always_comb begin
    err_pop = '0;
    for (int i = 0; i < N_CW; i++) err_pop = err_pop + POP_W'(dec_err_nxt[i]);
  end

  assign err_sum = {1'b0, err_cnt} + SUM_W'(err_pop);

  // Saturates at all-ones; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (load_dec) begin
      err_cnt <= err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    end
  end
`endif

endmodule
